// File: rtl/debounce3_if.sv
// debounce3_if: signal bundle between the raw-input source and the debouncer.
// The source drives the raw levels. The debouncer returns the filtered levels,
// the per-channel change pulses and the activity flag.
interface debounce3_if;
  logic [2:0] D;
  logic [2:0] Q;
  logic [2:0] CHG;
  logic       BUSY;

  modport master (output D, input Q, CHG, BUSY);
  modport slave  (input D, output Q, CHG, BUSY);
endinterface

// File: rtl/debounce3.sv
// debounce3: three independent synchroniser + debouncer channels.
// Each raw input passes through two flops. A new level is then accepted only
// after it has differed from the current output for STABLE_CYCLES consecutive
// clocks. Any sample that matches the current output clears the channel
// counter, so bounce back to the old level restarts the qualification.
module debounce3 #(
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned CNT_W         = 4,
  parameter logic [2:0]  RST_VAL       = 3'b000
) (
  input logic        CK,
  input logic        RST,
  debounce3_if.slave bus
);

  // Terminal count. STABLE_CYCLES-1 fits in CNT_W bits for every legal setting,
  // so the counter can never wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  generate
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > (2 ** CNT_W)) begin : g_bad_cfg
      $error("debounce3: STABLE_CYCLES=%0d outside legal range 2..%0d",
             STABLE_CYCLES, 2 ** CNT_W);
    end
  endgenerate

  logic [2:0]       sync_1;
  logic [2:0]       sync_2;
  logic [2:0]       q_r;
  logic [2:0]       chg_r;
  logic [CNT_W-1:0] cnt [3];

  // Two-flop synchroniser; only sync_2 is used downstream.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      sync_1 <= RST_VAL;
      sync_2 <= RST_VAL;
    end else begin
      sync_1 <= bus.D;
      sync_2 <= sync_1;
    end
  end

  // Per-channel stability counting, level acceptance and one-cycle change pulse.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      q_r   <= RST_VAL;
      chg_r <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_2[i] == q_r[i]) begin
          cnt[i]   <= '0;
          chg_r[i] <= 1'b0;
        end else if (cnt[i] == CNT_LAST) begin
          q_r[i]   <= sync_2[i];
          cnt[i]   <= '0;
          chg_r[i] <= 1'b1;
        end else begin
          cnt[i]   <= cnt[i] + CNT_W'(1);
          chg_r[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.Q    = q_r;
  assign bus.CHG  = chg_r;
  assign bus.BUSY = (cnt[0] != '0) || (cnt[1] != '0) || (cnt[2] != '0);

endmodule

// File: tb/tb_debounce3.sv
// tb_debounce3: directed scenarios plus randomized input activity, checked
// every cycle against a window-based model of the debounce rule.
module tb_debounce3;
  localparam int         STABLE = 8;
  localparam logic [2:0] RV     = 3'b000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  debounce3_if bus ();

  debounce3 #(
    .STABLE_CYCLES(STABLE),
    .CNT_W        (4),
    .RST_VAL      (RV)
  ) dut (
    .CK (clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: history of raw inputs seen at each clock since reset release.
  // The value judged at edge k is the raw input at edge k-2 (reset value
  // before that). A channel flips when the last STABLE judged samples all
  // differ from its level and all came after its previous flip.
  logic [2:0] dq[$];
  int         e;
  int         last_upd [3];
  logic [2:0] q_m;
  logic [2:0] chg_m;
  logic       busy_m;

  function automatic logic [2:0] s_at(input int k);
    if (k <= 2) return RV;
    return dq[k-3];
  endfunction

  task automatic model_reset();
    dq.delete();
    e      = 0;
    q_m    = RV;
    chg_m  = '0;
    busy_m = 1'b0;
    for (int i = 0; i < 3; i++) last_upd[i] = 0;
  endtask

  task automatic model_step(input logic [2:0] d);
    logic [2:0] sv;
    logic       ok;
    e++;
    dq.push_back(d);
    for (int i = 0; i < 3; i++) begin
      ok = (e - STABLE >= last_upd[i]);
      for (int k = e - STABLE + 1; ok && k <= e; k++) begin
        sv = s_at(k);
        if (sv[i] == q_m[i]) ok = 1'b0;
      end
      if (ok) begin
        q_m[i]      = ~q_m[i];
        last_upd[i] = e;
        chg_m[i]    = 1'b1;
      end else begin
        chg_m[i] = 1'b0;
      end
    end
    sv     = s_at(e);
    busy_m = ((sv ^ q_m) != 3'b000);
  endtask

  // Model advances on the same edges as the design.
  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step(bus.D);
  end

  // Every-cycle comparison, sampled on the falling edge.
  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      if (rst) begin
        check("rst_q",    bus.Q,    RV);
        check("rst_chg",  bus.CHG,  3'b000);
        check("rst_busy", bus.BUSY, 1'b0);
      end else begin
        check("model_q",    bus.Q,    q_m);
        check("model_chg",  bus.CHG,  chg_m);
        check("model_busy", bus.BUSY, busy_m);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    bus.D = 3'b000;
    #1;
    check("async_rst_q",    bus.Q,    RV);
    check("async_rst_chg",  bus.CHG,  3'b000);
    check("async_rst_busy", bus.BUSY, 1'b0);
    step(2);
    rst = 1'b0;
    step(3);
  endtask

  logic [2:0] chg_acc;
  int         pulses;

  initial begin
    bus.D = 3'b111;
    @(posedge clk);
    #2;
    cmp_en = 1'b1;

    // 1: reset with all inputs high, then quiet release
    step(3);
    check("t1_q",    bus.Q,    3'b000);
    check("t1_chg",  bus.CHG,  3'b000);
    check("t1_busy", bus.BUSY, 1'b0);
    bus.D = 3'b000;
    rst   = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      check("t1_hold_q", bus.Q, 3'b000);
    end

    // 2: clean single-channel edge
    bus.D = 3'b001;
    for (int k = 1; k <= 11; k++) begin
      step(1);
      if (k == 2) check("t2_busy_e2", bus.BUSY, 1'b0);
      if (k == 3) check("t2_busy_e3", bus.BUSY, 1'b1);
      if (k == 9) begin
        check("t2_q_e9",    bus.Q,    3'b000);
        check("t2_busy_e9", bus.BUSY, 1'b1);
      end
      if (k == 10) begin
        check("t2_q_e10",    bus.Q,    3'b001);
        check("t2_chg_e10",  bus.CHG,  3'b001);
        check("t2_busy_e10", bus.BUSY, 1'b0);
        check("t2_model_q",  q_m,      3'b001);
      end
      if (k == 11) check("t2_chg_e11", bus.CHG, 3'b000);
    end

    // 3: bounce on channel 1 restarts qualification
    do_reset();
    pulses = 0;
    bus.D  = 3'b010;
    for (int k = 0; k < 5; k++) begin step(1); pulses += int'(bus.CHG[1]); end
    bus.D = 3'b000;
    step(1);
    pulses += int'(bus.CHG[1]);
    bus.D = 3'b010;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      pulses += int'(bus.CHG[1]);
      if (k == 9)  check("t3_q1_e9",  bus.Q[1], 1'b0);
      if (k == 10) check("t3_q1_e10", bus.Q[1], 1'b1);
    end
    check("t3_pulses", pulses, 1);

    // 4: simultaneous update, then a single-channel fall
    do_reset();
    bus.D = 3'b111;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (k == 10) begin
        check("t4_q_all",   bus.Q,   3'b111);
        check("t4_chg_all", bus.CHG, 3'b111);
        check("t4_model_chg", chg_m, 3'b111);
      end
    end
    step(3);
    bus.D   = 3'b101;
    chg_acc = '0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chg_acc |= bus.CHG;
      if (k == 10) begin
        check("t4_q_101",   bus.Q,   3'b101);
        check("t4_chg_010", bus.CHG, 3'b010);
      end
    end
    check("t4_chg_only_1", chg_acc, 3'b010);

    // 5: reset in the middle of a count
    do_reset();
    bus.D = 3'b100;
    step(5);
    check("t5_busy_pre", bus.BUSY, 1'b1);
    rst = 1'b1;
    #1;
    check("t5_q_rst",    bus.Q,    3'b000);
    check("t5_busy_rst", bus.BUSY, 1'b0);
    step(1);
    rst     = 1'b0;
    chg_acc = '0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (k < 10) chg_acc |= bus.CHG;
      if (k == 9) check("t5_q_e9", bus.Q, 3'b000);
      if (k == 10) begin
        check("t5_q_e10",   bus.Q,   3'b100);
        check("t5_chg_e10", bus.CHG, 3'b100);
      end
    end
    check("t5_no_early_chg", chg_acc, 3'b000);

    // 6: glitch one cycle shorter than the qualification window
    do_reset();
    bus.D = 3'b001;
    step(7);
    bus.D   = 3'b000;
    chg_acc = '0;
    for (int k = 0; k < 15; k++) begin
      step(1);
      chg_acc |= bus.CHG;
    end
    check("t6_q",    bus.Q,    3'b000);
    check("t6_chg",  chg_acc,  3'b000);
    check("t6_busy", bus.BUSY, 1'b0);

    // Randomized activity: short bounces, long holds, single-bit flips, resets
    do_reset();
    for (int n = 0; n < 2500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst = 1'b1;
        step(1 + $urandom_range(0, 2));
        rst = 1'b0;
      end else if (r < 30) begin
        bus.D = bus.D ^ (3'b001 << $urandom_range(0, 2));
        step($urandom_range(1, 10));
      end else if (r < 60) begin
        bus.D = 3'($urandom_range(0, 7));
        step($urandom_range(1, 4));
      end else begin
        bus.D = 3'($urandom_range(0, 7));
        step($urandom_range(6, 14));
      end
    end

    step(2);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
